// File: rtl/prf_free_list_pkg.sv
// Shared core types for the rename path: PRF sizing, tag and free-list pointer types.
// Also imported by the RAT, ARF and ROB.
package prf_free_list_pkg;

   localparam int NUM_PRF = 32;
   localparam int NUM_ARF = 8;
   localparam int TAG_W   = $clog2(NUM_PRF);

   typedef logic [TAG_W-1:0] tag_t;
   typedef logic [TAG_W:0]   fl_ptr_t;

   // Index bits wrap modulo NUM_PRF; the extra top bit toggles on each wrap.
   function automatic fl_ptr_t ptr_inc(input fl_ptr_t p);
      return p + fl_ptr_t'(1);
   endfunction

   function automatic tag_t ptr_index(input fl_ptr_t p);
      return p[TAG_W-1:0];
   endfunction

endpackage

// File: rtl/prf_free_list_if.sv
// Rename/commit-side signals of the PRF free list.
// The slave modport is the free list itself; the master is the rename/commit logic.
interface prf_free_list_if;
   import prf_free_list_pkg::*;

   logic    stop;
   logic    alloc_req;
   tag_t    tag_PRF;
   logic    alloc_gnt;
   logic    empty;
   logic    commit_valid;
   tag_t    commit_tag_old;
   fl_ptr_t free_count;
   logic    err;

   modport slave (
      input  stop, alloc_req, commit_valid, commit_tag_old,
      output tag_PRF, alloc_gnt, empty, free_count, err
   );

   modport master (
      output stop, alloc_req, commit_valid, commit_tag_old,
      input  tag_PRF, alloc_gnt, empty, free_count, err
   );

endinterface

// File: rtl/prf_free_list.sv
// Physical-register free list with a speculative head and a committed head,
// so that a stop rolls every speculative allocation back in one cycle.
module prf_free_list
   import prf_free_list_pkg::*;
(
   input logic              clk,
   input logic              rst,
   prf_free_list_if.slave   bus
);

   tag_t    entries [NUM_PRF];
   fl_ptr_t head;
   fl_ptr_t arch_head;
   fl_ptr_t tail;
   logic    err_q;

   fl_ptr_t head_next;
   fl_ptr_t arch_head_next;
   fl_ptr_t tail_next;
   fl_ptr_t free_count;
   logic    empty;
   logic    alloc_gnt;
   logic    err_set;

   assign empty      = (head == tail);
   assign free_count = tail - head;
   assign alloc_gnt  = bus.alloc_req && !empty && !bus.stop;

   assign bus.tag_PRF    = entries[ptr_index(head)];
   assign bus.empty      = empty;
   assign bus.free_count = free_count;
   assign bus.alloc_gnt  = alloc_gnt;
   assign bus.err        = err_q;

   // Recovery reloads head from the committed head including this cycle's commit.
   always_comb begin
      arch_head_next = arch_head;
      tail_next      = tail;
      if (bus.commit_valid) begin
         arch_head_next = ptr_inc(arch_head);
         tail_next      = ptr_inc(tail);
      end
      head_next = head;
      if (bus.stop) begin
         head_next = arch_head_next;
      end else if (alloc_gnt) begin
         head_next = ptr_inc(head);
      end
   end

   assign err_set = bus.commit_valid &&
                    (((arch_head == head) && !alloc_gnt) ||
                     (free_count == fl_ptr_t'(NUM_PRF)));

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_PRF; i++) begin
            entries[i] <= (i < NUM_PRF - NUM_ARF) ? tag_t'(i + NUM_ARF) : '0;
         end
         head      <= '0;
         arch_head <= '0;
         tail      <= fl_ptr_t'(NUM_PRF - NUM_ARF);
         err_q     <= 1'b0;
      end else begin
         if (bus.commit_valid) begin
            entries[ptr_index(tail)] <= bus.commit_tag_old;
         end
         head      <= head_next;
         arch_head <= arch_head_next;
         tail      <= tail_next;
         if (err_set) begin
            err_q <= 1'b1;
         end
      end
   end

endmodule

// File: doc/prf_free_list.md
# prf_free_list

Physical-register free-list controller for the out-of-order single-issue core: supplies the next free PRF tag to rename (the RAT's `tag_PRF` input) and reclaims the previous mapping (`tag_Rw_old`) when the renaming instruction commits. It keeps a speculative head and a committed head so that a `stop` recovery rolls back every speculative allocation in one cycle, matching the RAT's restore-from-ARF behaviour. It sits beside the RAT in the ID stage; its `empty` output feeds the front-end freeze logic.

## Interface
- `NUM_PRF`, 32: physical registers; must be a power of two.
- `NUM_ARF`, 8: architectural registers; tags `0..NUM_ARF-1` are mapped at reset.
- `TAG_W`, 5: tag width, equal to log2(`NUM_PRF`).
- `clk`  in  1  clock; the block uses one clock.
- `rst`  in  1  reset; synchronous and active-high.
- `stop`  in  1  recovery: discard every speculative allocation.
- `alloc_req`  in  1  rename consumes a tag this cycle (`valid_issue && !freeze_front && Rw != 0`).
- `tag_PRF`  out  TAG_W  tag at the speculative head; valid whenever `empty`=0.
- `alloc_gnt`  out  1  `alloc_req && !empty && !stop`.
- `empty`  out  1  no free tag; the front end must freeze.
- `commit_valid`  in  1  an instruction with a destination register commits.
- `commit_tag_old`  in  TAG_W  stale tag released by that commit.
- `free_count`  out  TAG_W+1  tail minus speculative head.
- `err`  out  1  sticky protocol-violation flag.

## Operation
- Storage: a circular array of `NUM_PRF` tags plus three pointers of TAG_W+1 bits each (index plus wrap bit):
  - `head`: speculative allocate pointer.
  - `arch_head`: committed allocate pointer.
  - `tail`: free/insert pointer.
- Reset state:
  - entry[i] = i+`NUM_ARF` for i < `NUM_PRF-NUM_ARF`; the remaining entries are 0.
  - `head` = `arch_head` = 0, `tail` = 24.
  - Outputs: `tag_PRF` = 8, `empty` = 0, `free_count` = 24, `alloc_gnt` = `alloc_req`, `err` = 0.
- Allocate: when `alloc_gnt`=1, `head` increments, so the next cycle presents the next tag. When `empty`=1, `alloc_req` is ignored and `err` is not set.
- Commit: when `commit_valid`=1:
  - entry[`tail`] is written with `commit_tag_old`, and `tail` increments.
  - `arch_head` increments, because every committed destination instruction consumed exactly one allocation.
- Recover: when `stop`=1, `head` is loaded with `arch_head_next`, which includes a commit in the same cycle. Allocation is suppressed in that cycle. `tail` and the array are updated normally.
- Priority: `rst` > `stop` > allocate. Commit is independent of allocate and is applied on `stop` cycles.
- No bypass: a tag freed in cycle N is not visible at `tag_PRF` before cycle N+1, even if `empty` was 1.
- Wrap-around: an index wraps modulo `NUM_PRF` and its wrap bit toggles.
  - `empty` = (`head` == `tail`).
  - `free_count` = `tail` − `head` (TAG_W+1-bit modular arithmetic).
- `err` sets and holds until `rst` on either condition:
  - `commit_valid` while `arch_head == head` and `alloc_gnt`=0: committing an allocation that never happened.
  - `commit_valid` while `free_count == NUM_PRF`: overflow.

## Timing
- Single cycle. `tag_PRF`, `empty` and `free_count` depend only on registers, not on same-cycle inputs.
- `alloc_gnt` is combinational from `alloc_req`, `empty` and `stop`.
- All state updates on the rising edge of `clk`.
- Rollback latency: the first `tag_PRF` after `stop` is valid in the cycle following `stop`.
- Allocate and commit in the same cycle: `free_count` is unchanged, and the head and tail both advance.

## Structure
- Shared core package:
  - `NUM_PRF`, `NUM_ARF`, `TAG_W`.
  - `typedef logic [TAG_W-1:0] tag_t`.
  - `typedef logic [TAG_W:0] fl_ptr_t`.
  - Use these in the RAT, ARF and ROB as well.
- One module, no sub-modules. The pointer-increment function belongs in the package.

## Test plan
- Reset, then 24 consecutive `alloc_req` -> tags 8..31 in order; `empty`=1 after the 24th; a 25th request gives `alloc_gnt`=0 and state unchanged.
- Drain to empty, then `commit_valid` with `commit_tag_old`=3 -> `empty` still 1 in that cycle; next cycle `tag_PRF`=3 and `free_count`=1.
- 5 allocations (tags 8..12), commit 2 (old tags 0,1), then `stop` -> next cycle `tag_PRF`=10 and `free_count`=24.
- `stop` in the same cycle as `commit_valid` and `alloc_req` -> `alloc_gnt`=0; `head` = `arch_head` after the increment; the freed tag is appended at `tail`.
- 100 alloc/commit cycles across wrap-around -> `free_count` stays correct, and the tags form a permutation with no duplicates among allocated, free and architectural tags.
- `commit_valid` with no outstanding allocation -> `err`=1 from the next cycle, held until `rst`.
